// File: rtl/moxie_wb_pkg.sv
// Shared encodings and bus widths for the MoxieLite two-master Wishbone arbiter.
package moxie_wb_pkg;
  localparam int WB_DW = 16;
  localparam int WB_AW = 32;
  localparam int WB_SW = 2;
  localparam logic [WB_DW-1:0] TIMEOUT_DATA = 16'hDEAD;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_e;

  typedef struct packed {
    logic [WB_AW-1:0] adr;
    logic [WB_DW-1:0] dat;
    logic [WB_SW-1:0] sel;
    logic             we;
    logic             cyc;
    logic             stb;
  } wb_req_t;
endpackage

// File: rtl/moxie_wb_watchdog.sv
// Saturating stall counter; fire marks the cycle an unacked strobe has waited TIMEOUT cycles.
module moxie_wb_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic run,
  output logic fire
);
  localparam logic [TO_W-1:0] LIMIT   = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] CNT_MAX = '1;

  if (TIMEOUT < 1 || TIMEOUT > 2**TO_W - 1) begin : g_bad_timeout
    $error("moxie_wb_watchdog: TIMEOUT must be in 1..2**TO_W-1");
  end

  logic [TO_W-1:0] cnt_q, cnt_d;

  assign fire = run && (cnt_q == LIMIT);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || fire)
      cnt_d = '0;
    else if (run && cnt_q != CNT_MAX)
      cnt_d = cnt_q + TO_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/moxie_wb_arbiter.sv
// Two-master round-robin Wishbone arbiter with per-access ownership and a stall watchdog.
module moxie_wb_arbiter
  import moxie_wb_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8,
  parameter int M0_PRIO = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WB_AW-1:0] m0_adr_i,
  input  logic [WB_DW-1:0] m0_dat_i,
  input  logic [WB_SW-1:0] m0_sel_i,
  input  logic             m0_we_i,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  output logic [WB_DW-1:0] m0_dat_o,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  output logic             m0_gnt_o,
  input  logic [WB_AW-1:0] m1_adr_i,
  input  logic [WB_DW-1:0] m1_dat_i,
  input  logic [WB_SW-1:0] m1_sel_i,
  input  logic             m1_we_i,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  output logic [WB_DW-1:0] m1_dat_o,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic             m1_gnt_o,
  output logic [WB_AW-1:0] s_adr_o,
  output logic [WB_DW-1:0] s_dat_o,
  output logic [WB_SW-1:0] s_sel_o,
  output logic             s_we_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  input  logic [WB_DW-1:0] s_dat_i,
  input  logic             s_ack_i
);
  state_e  state_q, state_d;
  logic    last_q, last_d;
  wb_req_t [1:0] m_req;
  wb_req_t own;
  logic [1:0] req;
  logic    own_vld, own_idx, to_fire;
  logic [1:0] m_ack, m_err;
  logic [1:0][WB_DW-1:0] m_dat;

  assign m_req[0] = '{adr: m0_adr_i, dat: m0_dat_i, sel: m0_sel_i, we: m0_we_i, cyc: m0_cyc_i, stb: m0_stb_i};
  assign m_req[1] = '{adr: m1_adr_i, dat: m1_dat_i, sel: m1_sel_i, we: m1_we_i, cyc: m1_cyc_i, stb: m1_stb_i};
  assign req      = {m1_cyc_i & m1_stb_i, m0_cyc_i & m0_stb_i};
  assign own_vld  = (state_q != ST_IDLE);
  assign own_idx  = (state_q == ST_OWN1);
  assign own      = m_req[own_idx];

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (&req)       state_d = last_q ? ST_OWN0 : ST_OWN1;
        else if (req[0]) state_d = ST_OWN0;
        else if (req[1]) state_d = ST_OWN1;
      end
      ST_OWN0: if (!m0_cyc_i) begin state_d = ST_IDLE; last_d = 1'b0; end
      ST_OWN1: if (!m1_cyc_i) begin state_d = ST_IDLE; last_d = 1'b1; end
      default: state_d = ST_IDLE;
    endcase
  end

  // last is the most recently served master, so seeding it with 1 lets master 0 win the first tie
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      last_q  <= (M0_PRIO != 0);
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  moxie_wb_watchdog #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_wdog (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (!own_vld || !own.stb || s_ack_i),
    .run   (own_vld && own.stb && !s_ack_i),
    .fire  (to_fire)
  );

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    m_ack   = '0;
    m_err   = '0;
    m_dat   = '0;
    if (!rst_i && own_vld) begin
      s_adr_o = own.adr;
      s_dat_o = own.dat;
      s_sel_o = own.sel;
      s_we_o  = own.we;
      s_cyc_o = own.cyc;
      s_stb_o = own.stb && !to_fire;
      // a timeout looks like an ack with err so the CPU wait path is released
      m_ack[own_idx] = (s_ack_i && own.cyc) || to_fire;
      m_err[own_idx] = to_fire;
      m_dat[own_idx] = to_fire ? TIMEOUT_DATA : s_dat_i;
    end
  end

  assign m0_ack_o = m_ack[0];
  assign m1_ack_o = m_ack[1];
  assign m0_err_o = m_err[0];
  assign m1_err_o = m_err[1];
  assign m0_dat_o = m_dat[0];
  assign m1_dat_o = m_dat[1];
  assign m0_gnt_o = !rst_i && (state_q == ST_OWN0);
  assign m1_gnt_o = !rst_i && (state_q == ST_OWN1);
endmodule
